// File: rtl/ssd_pkg.sv
// Shared types and constants for the generation-count seven-segment scheduler.
// Holds the conversion FSM states, display constants and the double-dabble helpers.
package ssd_pkg;

  localparam int unsigned GEN_W  = 16;
  localparam int unsigned BCD_W  = 16;
  localparam int unsigned ITER_W = 4;

  localparam logic [GEN_W-1:0] GEN_MAX    = 16'd9999;
  localparam logic [3:0]       BLANK_CODE = 4'hF;

  localparam logic [3:0] AN_THOU = 4'b0111;
  localparam logic [3:0] AN_HUND = 4'b1011;
  localparam logic [3:0] AN_TENS = 4'b1101;
  localparam logic [3:0] AN_UNIT = 4'b1110;
  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CONV = 2'd2,
    ST_DONE = 2'd3
  } conv_state_e;

  // A conversion request: clamped value plus the flag saying it was clamped.
  typedef struct packed {
    logic             ovf;
    logic [GEN_W-1:0] val;
  } gen_req_t;

  function automatic gen_req_t clamp_gen(input logic [GEN_W-1:0] g);
    gen_req_t r;
    r.ovf = (g > GEN_MAX);
    r.val = r.ovf ? GEN_MAX : g;
    return r;
  endfunction

  // Double-dabble correction step: add 3 to every nibble that is 5 or more.
  function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/ssd_digit_decoder.sv
// Combinational BCD/blank code to active-low {a,b,c,d,e,f,g} segment decoder.
module ssd_digit_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = 7'b0000001;
    case (code)
      4'd0:       seg_c = 7'b0000001;
      4'd1:       seg_c = 7'b1001111;
      4'd2:       seg_c = 7'b0010010;
      4'd3:       seg_c = 7'b0000110;
      4'd4:       seg_c = 7'b1001100;
      4'd5:       seg_c = 7'b0100100;
      4'd6:       seg_c = 7'b0100000;
      4'd7:       seg_c = 7'b0001111;
      4'd8:       seg_c = 7'b0000000;
      4'd9:       seg_c = 7'b0000100;
      BLANK_CODE: seg_c = SEG_OFF;
      default:    seg_c = 7'b0000001;
    endcase
  end

endmodule

// File: rtl/ssd_generation_scheduler.sv
// Sequential binary-to-BCD conversion of the generation count with atomic display commit,
// a one-deep pending request slot, and a free-running anode scan with leading-zero blanking.
module ssd_generation_scheduler
  import ssd_pkg::*;
#(
  parameter int unsigned REFRESH_W = 21,
  parameter bit          BLANK_LZ  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [GEN_W-1:0] generation,
  input  logic             gen_valid,
  output logic             busy,
  output logic             overflow,
  output logic [3:0]       anode,
  output logic [6:0]       ssdOut
);

  conv_state_e          state_q, state_d;
  logic [GEN_W-1:0]     bin_q, bin_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [ITER_W-1:0]    iter_q, iter_d;
  logic                 ovf_next_q, ovf_next_d;
  gen_req_t             pend_q, pend_d;
  logic                 pend_vld_q, pend_vld_d;
  logic [BCD_W-1:0]     digits_q, digits_d;
  logic                 overflow_q, overflow_d;
  logic                 busy_q, busy_d;
  logic [REFRESH_W-1:0] refresh_q, refresh_d;
  logic [3:0]           anode_q, anode_d;
  logic [6:0]           seg_q;

  gen_req_t   req_new, req_cap;
  logic [1:0] sel;
  logic [3:0] digit, code, an_sel;
  logic       blank, lz_th, lz_hu, lz_te;
  logic [6:0] seg_c;

  // Conversion FSM, pending slot and display commit.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    iter_d     = iter_q;
    ovf_next_d = ovf_next_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    digits_d   = digits_q;
    overflow_d = overflow_q;
    req_new    = clamp_gen(generation);
    req_cap    = gen_valid ? req_new : pend_q;

    if (gen_valid && (state_q == ST_LOAD || state_q == ST_CONV)) begin
      pend_d     = req_new;
      pend_vld_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (gen_valid) begin
          bin_d      = req_new.val;
          ovf_next_d = req_new.ovf;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        bcd_d   = '0;
        iter_d  = '0;
        state_d = ST_CONV;
      end
      ST_CONV: begin
        {bcd_d, bin_d} = {add3_nibbles(bcd_q), bin_q} << 1;
        iter_d         = iter_q + ITER_W'(1);
        if (iter_q == ITER_W'(15)) state_d = ST_DONE;
      end
      ST_DONE: begin
        digits_d   = bcd_q;
        overflow_d = ovf_next_q;
        // A strobe arriving in this cycle is newer than anything in the slot.
        if (gen_valid || pend_vld_q) begin
          bin_d      = req_cap.val;
          ovf_next_d = req_cap.ovf;
          pend_vld_d = 1'b0;
          state_d    = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Held until the cycle after the commit so new digits are visible when busy drops.
    busy_d = (state_q != ST_IDLE) || (state_d != ST_IDLE);
  end

  // Scan select, leading-zero blanking and digit mux.
  always_comb begin
    refresh_d = refresh_q + REFRESH_W'(1);
    sel       = refresh_q[REFRESH_W-1 -: 2];
    lz_th     = (digits_q[15:12] == 4'd0);
    lz_hu     = lz_th && (digits_q[11:8] == 4'd0);
    lz_te     = lz_hu && (digits_q[7:4] == 4'd0);
    digit     = digits_q[3:0];
    an_sel    = AN_UNIT;
    blank     = 1'b0;
    case (sel)
      2'd0: begin digit = digits_q[15:12]; an_sel = AN_THOU; blank = lz_th; end
      2'd1: begin digit = digits_q[11:8];  an_sel = AN_HUND; blank = lz_hu; end
      2'd2: begin digit = digits_q[7:4];   an_sel = AN_TENS; blank = lz_te; end
      2'd3: begin digit = digits_q[3:0];   an_sel = AN_UNIT; blank = 1'b0;  end
      default: ;
    endcase
    blank   = blank && BLANK_LZ;
    code    = blank ? BLANK_CODE : digit;
    anode_d = blank ? AN_OFF : an_sel;
  end

  ssd_digit_decoder u_dec (
    .code  (code),
    .seg_c (seg_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      ovf_next_q <= 1'b0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      digits_q   <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      refresh_q  <= '0;
      anode_q    <= AN_OFF;
      seg_q      <= SEG_OFF;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      iter_q     <= iter_d;
      ovf_next_q <= ovf_next_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      digits_q   <= digits_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      refresh_q  <= refresh_d;
      anode_q    <= anode_d;
      seg_q      <= seg_c;
    end
  end

  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign anode    = anode_q;
  assign ssdOut   = seg_q;

endmodule
